// File: rtl/alarm_zone_ctrl.sv
// Multi-zone intrusion alarm controller: arm refusal, entry delay, siren timeout
// with silenced state, latched trigger memory and status LED blink patterns.
module alarm_zone_ctrl #(
    parameter int unsigned N_ZONES       = 4,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned LED_SLOW_CNT  = 240000,
    parameter int unsigned LED_FAST_CNT  = 48000,
    parameter int unsigned ENTRY_DLY_CNT = 4800000,
    parameter int unsigned SIREN_TMO_CNT = 9600000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cr,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic [N_ZONES-1:0] zone_en,
    input  logic [N_ZONES-1:0] zone_dly,
    output logic               sirene,
    output logic               led,
    output logic               armed,
    output logic               arm_fail,
    output logic [N_ZONES-1:0] alarm_zone,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_ENTRY    = 3'd2,
        S_ALARM    = 3'd3,
        S_SILENCED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DLY_CNT - 1);
    localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_TMO_CNT - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(LED_SLOW_CNT - 1);
    localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(LED_FAST_CNT - 1);

    state_t             r_state, w_state_nxt;
    logic               r_cr_q;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [CNT_W-1:0]   r_blink, w_blink_nxt;
    logic               r_led, w_led_nxt;
    logic               r_sirene, r_armed;
    logic               r_arm_fail, w_arm_fail_nxt;
    logic [N_ZONES-1:0] r_alarm_zone, w_alarm_zone_nxt;
    logic [N_ZONES-1:0] w_act, w_imm, w_del, w_new;
    logic               w_cr_rise;

    assign w_cr_rise = cr & ~r_cr_q;
    assign w_act     = zone_in & zone_en;
    assign w_imm     = w_act & ~zone_dly;
    assign w_del     = w_act & zone_dly;
    assign w_new     = w_act & ~r_alarm_zone;

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = '0;
        w_arm_fail_nxt   = 1'b0;
        w_alarm_zone_nxt = r_alarm_zone | w_act;
        w_blink_nxt      = '0;
        w_led_nxt        = 1'b1;

        case (r_state)
            S_DISARMED: begin
                w_alarm_zone_nxt = r_alarm_zone;
                if (w_cr_rise) begin
                    if (w_act == '0) begin
                        w_state_nxt      = S_ARMED;
                        w_alarm_zone_nxt = '0;
                    end else begin
                        w_arm_fail_nxt = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (w_cr_rise)           w_state_nxt = S_DISARMED;
                else if (w_imm != '0)    w_state_nxt = S_ALARM;
                else if (w_del != '0)    w_state_nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (w_cr_rise)                  w_state_nxt = S_DISARMED;
                else if (w_imm != '0)           w_state_nxt = S_ALARM;
                else if (r_timer == ENTRY_LAST) w_state_nxt = S_ALARM;
                else                            w_timer_nxt = r_timer + 1'b1;
            end
            S_ALARM: begin
                if (w_cr_rise)                  w_state_nxt = S_DISARMED;
                else if (r_timer == SIREN_LAST) w_state_nxt = S_SILENCED;
                else                            w_timer_nxt = r_timer + 1'b1;
            end
            S_SILENCED: begin
                if (w_cr_rise)           w_state_nxt = S_DISARMED;
                else if (w_new != '0)    w_state_nxt = S_ALARM;
            end
            default: begin
                w_state_nxt      = S_DISARMED;
                w_alarm_zone_nxt = '0;
            end
        endcase

        // Any state change restarts the blink phase with the LED lit.
        if (w_state_nxt == r_state) begin
            case (r_state)
                S_ARMED, S_SILENCED: begin
                    if (r_blink == SLOW_LAST) w_led_nxt = ~r_led;
                    else begin
                        w_blink_nxt = r_blink + 1'b1;
                        w_led_nxt   = r_led;
                    end
                end
                S_ENTRY, S_ALARM: begin
                    if (r_blink == FAST_LAST) w_led_nxt = ~r_led;
                    else begin
                        w_blink_nxt = r_blink + 1'b1;
                        w_led_nxt   = r_led;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_DISARMED;
            r_cr_q       <= 1'b1;
            r_timer      <= '0;
            r_blink      <= '0;
            r_led        <= 1'b1;
            r_sirene     <= 1'b0;
            r_armed      <= 1'b0;
            r_arm_fail   <= 1'b0;
            r_alarm_zone <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cr_q       <= cr;
            r_timer      <= w_timer_nxt;
            r_blink      <= w_blink_nxt;
            r_led        <= w_led_nxt;
            r_sirene     <= (w_state_nxt == S_ALARM);
            r_armed      <= (w_state_nxt != S_DISARMED);
            r_arm_fail   <= w_arm_fail_nxt;
            r_alarm_zone <= w_alarm_zone_nxt;
        end
    end

    assign sirene     = r_sirene;
    assign led        = r_led;
    assign armed      = r_armed;
    assign arm_fail   = r_arm_fail;
    assign alarm_zone = r_alarm_zone;
    assign state      = r_state;
endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: constant vector table, hand-written corner sequences
// and a randomized run against a dwell-time based behavioural model.
module tb_alarm_zone_ctrl;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int EDLY = 10;
    localparam int STMO = 20;
    localparam int DIS = 0, ARM = 1, ENT = 2, ALM = 3, SIL = 4;

    logic       clk = 1'b0;
    logic       reset, cr;
    logic [3:0] zone_in, zone_en, zone_dly;
    logic       sirene, led, armed, arm_fail;
    logic [3:0] alarm_zone;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Model: state number plus cycles spent in it; LED and timers derive from dwell.
    int         m_st, m_dwell;
    logic       m_led, m_af, m_crq;
    logic [3:0] m_az;

    typedef struct {
        logic       c;
        logic [3:0] zi;
        int         st;
        logic       arm;
        logic       af;
        logic [3:0] az;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    alarm_zone_ctrl #(
        .N_ZONES(4), .CNT_W(24), .LED_SLOW_CNT(SLOW), .LED_FAST_CNT(FAST),
        .ENTRY_DLY_CNT(EDLY), .SIREN_TMO_CNT(STMO)
    ) dut (
        .clk(clk), .reset(reset), .cr(cr), .zone_in(zone_in), .zone_en(zone_en),
        .zone_dly(zone_dly), .sirene(sirene), .led(led), .armed(armed),
        .arm_fail(arm_fail), .alarm_zone(alarm_zone), .state(state)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic       rise;
        logic [3:0] act;
        int         nxt;
        if (reset) begin
            m_st = DIS; m_dwell = 0; m_led = 1'b1; m_af = 1'b0; m_az = '0; m_crq = 1'b1;
            return;
        end
        rise  = cr & ~m_crq;
        m_crq = cr;
        act   = zone_in & zone_en;
        nxt   = m_st;
        m_af  = 1'b0;
        case (m_st)
            DIS: if (rise) begin
                     if (act == 0) begin nxt = ARM; m_az = '0; end
                     else m_af = 1'b1;
                 end
            ARM: if (rise) nxt = DIS;
                 else if ((act & ~zone_dly) != 0) nxt = ALM;
                 else if (act != 0) nxt = ENT;
            ENT: if (rise) nxt = DIS;
                 else if ((act & ~zone_dly) != 0 || m_dwell == EDLY - 1) nxt = ALM;
            ALM: if (rise) nxt = DIS;
                 else if (m_dwell == STMO - 1) nxt = SIL;
            default: if (rise) nxt = DIS;
                 else if ((act & ~m_az) != 0) nxt = ALM;
        endcase
        if (m_st != DIS) m_az = m_az | act;
        if (nxt != m_st) m_dwell = 0;
        else m_dwell++;
        m_st = nxt;
        if (m_st == DIS || m_dwell == 0) m_led = 1'b1;
        else if (m_st == ARM || m_st == SIL) m_led = ((m_dwell / SLOW) % 2) == 0;
        else m_led = ((m_dwell / FAST) % 2) == 0;
    endtask

    task automatic step(input logic rst, input logic c, input logic [3:0] zi);
        reset   = rst;
        cr      = c;
        zone_in = zi;
        @(posedge clk);
        #1;
        model_edge();
        check("m_state", state, m_st);
        check("m_sirene", sirene, m_st == ALM);
        check("m_armed", armed, m_st != DIS);
        check("m_led", led, m_led);
        check("m_arm_fail", arm_fail, m_af);
        check("m_alarm_zone", alarm_zone, m_az);
    endtask

    initial begin
        int n;
        reset = 1'b1; cr = 1'b1; zone_in = '0; zone_en = 4'b1111; zone_dly = 4'b0001;

        // reset with cr held high
        step(1'b1, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        check("rst_state", state, 0);
        check("rst_sirene", sirene, 0);
        check("rst_led", led, 1);
        check("rst_armed", armed, 0);
        check("rst_arm_fail", arm_fail, 0);
        check("rst_alarm_zone", alarm_zone, 0);

        tbl[0]  = '{1'b1, 4'h0, 0, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'h0, 0, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'h0, 1, 1'b1, 1'b0, 4'h0};
        tbl[3]  = '{1'b1, 4'h0, 1, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 4'h0, 1, 1'b1, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 4'h0, 0, 1'b0, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 4'h4, 0, 1'b0, 1'b0, 4'h0};
        tbl[7]  = '{1'b1, 4'h4, 0, 1'b0, 1'b1, 4'h0};
        tbl[8]  = '{1'b1, 4'h4, 0, 1'b0, 1'b0, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 0, 1'b0, 1'b0, 4'h0};
        tbl[10] = '{1'b1, 4'h0, 1, 1'b1, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 4'h1, 2, 1'b1, 1'b0, 4'h1};
        tbl[12] = '{1'b0, 4'h0, 2, 1'b1, 1'b0, 4'h1};
        for (int i = 0; i < 13; i++) begin
            step(1'b0, tbl[i].c, tbl[i].zi);
            check("tbl_state", state, tbl[i].st);
            check("tbl_armed", armed, tbl[i].arm);
            check("tbl_arm_fail", arm_fail, tbl[i].af);
            check("tbl_alarm_zone", alarm_zone, tbl[i].az);
        end
        step(1'b0, 1'b1, 4'h0);
        check("disarm_entry", state, 0);

        // slow blink in ARMED
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("arm_led_start", led, 1);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b1, 4'h0);
            check("led_slow", led, ((k / 8) % 2) == 0);
        end
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);

        // entry delay runs out
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'b0001);
        check("entry_state", state, 2);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 4'h0);
            n++;
            if (state == 3'd3) break;
        end
        check("entry_len", n, 10);
        check("entry_sirene", sirene, 1);
        check("entry_alarm_zone", alarm_zone, 4'b0001);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);

        // entry delay cancelled by cr at cycle 5
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("rearm_clear", alarm_zone, 0);
        step(1'b0, 1'b0, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 4'h0);
            check("entry_hold", state, 2);
        end
        step(1'b0, 1'b1, 4'h0);
        check("cancel_state", state, 0);
        check("cancel_sirene", sirene, 0);

        // immediate zone, siren timeout, silenced retrigger rules
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'b0010);
        check("imm_state", state, 3);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 4'h0);
            if (state != 3'd3) break;
            n++;
        end
        check("siren_len", n, 20);
        check("silenced_state", state, 4);
        check("silenced_sirene", sirene, 0);
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0010);
        check("no_retrigger", state, 4);
        step(1'b0, 1'b0, 4'b1000);
        check("retrigger_state", state, 3);
        check("retrigger_zone", alarm_zone, 4'b1010);

        // cr wins over a new zone in ALARM
        step(1'b0, 1'b1, 4'b0100);
        check("crwin_state", state, 0);
        check("crwin_sirene", sirene, 0);
        check("crwin_led", led, 1);
        check("crwin_retained", alarm_zone & 4'b1010, 4'b1010);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("arm_clears_zone", alarm_zone, 0);

        // disabled zone ignored; reset during ALARM
        zone_en = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 4'b0001);
            check("disabled_state", state, 1);
            check("disabled_zone", alarm_zone, 0);
        end
        step(1'b0, 1'b1, 4'b0010);
        check("alarm_before_rst", sirene, 1);
        step(1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b1, 4'h0);
        check("midrst_state", state, 0);
        check("midrst_sirene", sirene, 0);
        check("midrst_led", led, 1);
        check("midrst_armed", armed, 0);
        check("midrst_alarm_zone", alarm_zone, 0);
        step(1'b0, 1'b1, 4'h0);
        check("post_rst_no_arm", state, 0);
        zone_en = 4'b1111;

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r, c;
            logic [3:0] z;
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 29) == 0) ? ~cr : cr;
            z = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 199) == 0) zone_en = 4'($urandom);
            if ($urandom_range(0, 199) == 0) zone_dly = 4'($urandom);
            step(r, c, z);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
